// File: rtl/tof_pkg.sv
// Shared definitions for the time-of-flight edge meter: FSM state encoding
// and default sizing of the separation counter.
package tof_pkg;

  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_IDLE    = 2'd1,
    ST_COUNT   = 2'd2
  } tof_state_e;

  localparam int CNT_W_DEF    = 8;
  localparam int MAX_WAIT_DEF = 255;

endpackage

// File: rtl/tof_edge_meter_rise_detect.sv
// Rising-edge detector for one already-synchronized pulse train: keeps the
// previous sample and flags a 0->1 transition combinationally.
module rise_detect (
  input  logic clk,
  input  logic reset_L,
  input  logic y,
  output logic rise
);

  logic y_d_q;

  // Previous-sample register; cleared on reset so a high input at release
  // looks like a rise (the meter's HOLDOFF state masks it).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      y_d_q <= 1'b0;
    end else begin
      y_d_q <= y;
    end
  end

  assign rise = y & ~y_d_q;

endmodule

// File: rtl/tof_edge_meter.sv
// Time-of-flight front end: measures the cycle separation between rising
// edges of Y1 and Y2, reports which edge led, and strobes tof_ready per
// valid measurement or tof_timeout when the partner edge never arrives.
module tof_edge_meter
  import tof_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             Y1,
  input  logic             Y2,
  output logic [CNT_W-1:0] tof_count,
  output logic             tof_sign,
  output logic             tof_ready,
  output logic             tof_timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic rise1;
  logic rise2;

  tof_state_e       state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             first_q,       first_d;
  logic [CNT_W-1:0] tof_count_q,   tof_count_d;
  logic             tof_sign_q,    tof_sign_d;
  logic             tof_ready_q,   tof_ready_d;
  logic             tof_timeout_q, tof_timeout_d;

  // Partner/leader rises as seen from the edge that started the count.
  logic other_rise;
  logic first_rise;

  rise_detect u_rise_y1 (
    .clk     (clk),
    .reset_L (reset_L),
    .y       (Y1),
    .rise    (rise1)
  );

  rise_detect u_rise_y2 (
    .clk     (clk),
    .reset_L (reset_L),
    .y       (Y2),
    .rise    (rise2)
  );

  assign other_rise = first_q ? rise1 : rise2;
  assign first_rise = first_q ? rise2 : rise1;

  // Next-state logic: HOLDOFF waits for both inputs low, IDLE arms on the
  // first rise, COUNT resolves partner edge > timeout > re-arm > increment.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    tof_count_d   = tof_count_q;
    tof_sign_d    = tof_sign_q;
    tof_ready_d   = 1'b0;
    tof_timeout_d = 1'b0;

    case (state_q)
      ST_HOLDOFF: begin
        if (!Y1 && !Y2) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (rise1 && rise2) begin
          tof_count_d = '0;
          tof_sign_d  = 1'b0;
          tof_ready_d = 1'b1;
          state_d     = ST_HOLDOFF;
        end else if (rise1) begin
          first_d = 1'b0;
          cnt_d   = CNT_ONE;
          state_d = ST_COUNT;
        end else if (rise2) begin
          first_d = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (other_rise) begin
          // Partner edge wins even if the leader re-rises in the same cycle.
          tof_count_d = cnt_q;
          tof_sign_d  = first_q;
          tof_ready_d = 1'b1;
          state_d     = ST_HOLDOFF;
        end else if (cnt_q == CNT_MAX) begin
          tof_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (first_rise) begin
          cnt_d = CNT_ONE;
        end else begin
          // Cannot wrap: the MAX_WAIT check above fires first.
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_HOLDOFF;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any measurement.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= ST_HOLDOFF;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      tof_count_q   <= '0;
      tof_sign_q    <= 1'b0;
      tof_ready_q   <= 1'b0;
      tof_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      tof_count_q   <= tof_count_d;
      tof_sign_q    <= tof_sign_d;
      tof_ready_q   <= tof_ready_d;
      tof_timeout_q <= tof_timeout_d;
    end
  end

  assign tof_count   = tof_count_q;
  assign tof_sign    = tof_sign_q;
  assign tof_ready   = tof_ready_q;
  assign tof_timeout = tof_timeout_q;

endmodule

// File: tb/tb_tof_edge_meter.sv
// Self-checking bench for tof_edge_meter: expected strobes are queued when
// stimulus is driven and matched (cycle, count, sign, kind) as they appear.
module tb_tof_edge_meter;

  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 255;

  typedef struct {
    int             cyc;
    logic [CNT_W-1:0] cnt;
    logic           sign;
    logic           is_to;
  } exp_t;

  logic             clk;
  logic             reset_L;
  logic             Y1;
  logic             Y2;
  logic [CNT_W-1:0] tof_count;
  logic             tof_sign;
  logic             tof_ready;
  logic             tof_timeout;

  int   cyc;
  int   tests_run;
  int   fails;
  exp_t exp_q[$];
  logic [CNT_W-1:0] last_cnt;
  logic             last_sign;

  tof_edge_meter #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .Y1          (Y1),
    .Y2          (Y2),
    .tof_count   (tof_count),
    .tof_sign    (tof_sign),
    .tof_ready   (tof_ready),
    .tof_timeout (tof_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: every strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_L && (tof_ready || tof_timeout)) begin
        tests_run++;
        if (tof_ready && tof_timeout) begin
          fails++;
          $display("FAIL strobe_overlap cyc=%0d ready=%b timeout=%b required one-hot", cyc, tof_ready, tof_timeout);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe cyc=%0d ready=%b timeout=%b count=%0d required no strobe", cyc, tof_ready, tof_timeout, tof_count);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || tof_count !== e.cnt || tof_sign !== e.sign || tof_timeout !== e.is_to) begin
            fails++;
            $display("FAIL strobe cyc=%0d count=%0d sign=%b timeout=%b required cyc=%0d count=%0d sign=%b timeout=%b",
                     cyc, tof_count, tof_sign, tof_timeout, e.cyc, e.cnt, e.sign, e.is_to);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1, "simulation did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every queued strobe must appear within the budget.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_strobe pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Leader rises in cycle t, trailer in cycle t+d (d==0: both together).
  task automatic run_pair(input bit y2_leads, input int d);
    exp_t e;
    int   t;
    t = cyc;
    if (d == 0) begin
      Y1 = 1'b1;
      Y2 = 1'b1;
    end else begin
      if (y2_leads) Y2 = 1'b1; else Y1 = 1'b1;
      repeat (d) tick();
      if (y2_leads) Y1 = 1'b1; else Y2 = 1'b1;
    end
    e.cyc   = t + d + 1;
    e.cnt   = CNT_W'(d);
    e.sign  = (d == 0) ? 1'b0 : y2_leads;
    e.is_to = 1'b0;
    exp_q.push_back(e);
    last_cnt  = e.cnt;
    last_sign = e.sign;
    tick();
    tick();
    Y1 = 1'b0;
    Y2 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    Y1      = 1'b1;
    Y2      = 1'b0;
    reset_L = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (tof_count !== 8'd0 || tof_sign !== 1'b0 || tof_ready !== 1'b0 || tof_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs count=%0d sign=%b ready=%b timeout=%b required 0 0 0 0", tof_count, tof_sign, tof_ready, tof_timeout);
    end
    reset_L = 1'b1;
    repeat (6) tick();
    Y1 = 1'b0;
    tick();
    tick();
    tests_run++;
    if (tof_count !== 8'd0 || tof_ready !== 1'b0) begin
      fails++;
      $display("FAIL holdoff_quiet count=%0d ready=%b required 0 0", tof_count, tof_ready);
    end
    run_pair(1'b0, 5);
    drain("y1_leads_5", 10);
    tests_run++;
    if (tof_count !== 8'd5 || tof_sign !== 1'b0) begin
      fails++;
      $display("FAIL hold_after_5 count=%0d sign=%b required 5 0", tof_count, tof_sign);
    end
  endtask

  task automatic test_y2_leads();
    run_pair(1'b1, 12);
    drain("y2_leads_12", 10);
    tests_run++;
    if (tof_count !== 8'd12 || tof_sign !== 1'b1) begin
      fails++;
      $display("FAIL hold_after_12 count=%0d sign=%b required 12 1", tof_count, tof_sign);
    end
  endtask

  task automatic test_coincident();
    run_pair(1'b1, 0);
    drain("coincident", 10);
    tests_run++;
    if (tof_count !== 8'd0 || tof_sign !== 1'b0) begin
      fails++;
      $display("FAIL hold_after_coincident count=%0d sign=%b required 0 0", tof_count, tof_sign);
    end
    run_pair(1'b0, 1);
    drain("y1_leads_1", 10);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   t;
    t       = cyc;
    Y1      = 1'b1;
    e.cyc   = t + MAX_WAIT + 1;
    e.cnt   = last_cnt;
    e.sign  = last_sign;
    e.is_to = 1'b1;
    exp_q.push_back(e);
    repeat (MAX_WAIT + 5) tick();
    drain("timeout", 5);
    tests_run++;
    if (tof_count !== 8'd1 || tof_sign !== 1'b0) begin
      fails++;
      $display("FAIL hold_after_timeout count=%0d sign=%b required 1 0", tof_count, tof_sign);
    end
    Y1 = 1'b0;
    tick();
    tick();
    run_pair(1'b0, 3);
    drain("after_timeout_3", 10);
    tests_run++;
    if (tof_count !== 8'd3) begin
      fails++;
      $display("FAIL count_after_timeout count=%0d required 3", tof_count);
    end
  endtask

  task automatic test_rearm();
    exp_t e;
    int   t;
    // Y1 at t, Y1 again at t+4, Y2 at t+10.
    t = cyc;
    for (int k = 0; k <= 10; k++) begin
      if (k == 0 || k == 4) Y1 = 1'b1;
      if (k == 2)           Y1 = 1'b0;
      if (k == 10)          Y2 = 1'b1;
      if (k != 10) tick();
    end
    e.cyc = t + 11; e.cnt = 8'd6; e.sign = 1'b0; e.is_to = 1'b0;
    exp_q.push_back(e);
    tick(); tick();
    Y1 = 1'b0; Y2 = 1'b0;
    tick(); tick();
    drain("rearm", 10);
    tests_run++;
    if (tof_count !== 8'd6) begin
      fails++;
      $display("FAIL rearm_count count=%0d required 6", tof_count);
    end
    // Y1 at t, Y1 and Y2 together at t+7: partner edge takes priority.
    t = cyc;
    for (int k = 0; k <= 7; k++) begin
      if (k == 0) Y1 = 1'b1;
      if (k == 3) Y1 = 1'b0;
      if (k == 7) begin Y1 = 1'b1; Y2 = 1'b1; end
      if (k != 7) tick();
    end
    e.cyc = t + 8; e.cnt = 8'd7; e.sign = 1'b0; e.is_to = 1'b0;
    exp_q.push_back(e);
    tick(); tick();
    Y1 = 1'b0; Y2 = 1'b0;
    tick(); tick();
    drain("rerise_with_partner", 10);
  endtask

  task automatic test_reset_mid();
    Y1 = 1'b1;
    repeat (3) tick();
    reset_L = 1'b0;
    #1;
    tests_run++;
    if (tof_count !== 8'd0 || tof_sign !== 1'b0 || tof_ready !== 1'b0 || tof_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs count=%0d sign=%b ready=%b timeout=%b required 0 0 0 0", tof_count, tof_sign, tof_ready, tof_timeout);
    end
    repeat (5) tick();
    Y2 = 1'b1;
    tick();
    reset_L = 1'b1;
    repeat (6) tick();
    tests_run++;
    if (tof_count !== 8'd0 || tof_sign !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_quiet count=%0d sign=%b required 0 0", tof_count, tof_sign);
    end
    Y1 = 1'b0;
    Y2 = 1'b0;
    tick();
    tick();
    run_pair(1'b0, 2);
    drain("after_reset_2", 10);
    tests_run++;
    if (tof_count !== 8'd2 || tof_sign !== 1'b0) begin
      fails++;
      $display("FAIL count_after_reset count=%0d sign=%b required 2 0", tof_count, tof_sign);
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    last_cnt  = '0;
    last_sign = 1'b0;
    reset_L   = 1'b0;
    Y1        = 1'b0;
    Y2        = 1'b0;
    test_reset();
    test_y2_leads();
    test_coincident();
    test_timeout();
    test_rearm();
    test_reset_mid();
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
